fixed_vector_fifo: RTL and testbench

Synchronous first-word-fall-through FIFO for SIZE-wide fixed-point vectors. It sits directly downstream of a layer's output (e.g. after `fixed_relu`, before the top-level `data_out` port or the next layer's `data_in`). It decouples producer and consumer valid/ready handshakes so a stalled consumer does not stall the layer pipeline until DEPTH vectors are buffered. Data is passed bit-exact; no casting or arithmetic is applied to payload.

---
 rtl/fixed_vector_fifo.sv | 65 ++++++
 tb/tb_fixed_vector_fifo.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/fixed_vector_fifo.sv
// fixed_vector_fifo: first-word-fall-through FIFO for SIZE x WIDTH vectors.
// Decouples a layer's output handshake from its consumer. The payload is opaque
// and is passed through bit-exact. DEPTH need not be a power of two.
module fixed_vector_fifo #(
    parameter int unsigned WIDTH       = 4,
    parameter int unsigned SIZE        = 2,
    parameter int unsigned DEPTH       = 4,
    parameter int unsigned COUNT_WIDTH = $clog2(DEPTH + 1)
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [SIZE-1:0][WIDTH-1:0]       data_in,
    input  logic                             data_in_valid,
    output logic                             data_in_ready,
    output logic [SIZE-1:0][WIDTH-1:0]       data_out,
    output logic                             data_out_valid,
    input  logic                             data_out_ready,
    output logic [COUNT_WIDTH-1:0]           count
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [SIZE-1:0][WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0]           wr_ptr;
    logic [PTR_W-1:0]           rd_ptr;
    logic                       push;
    logic                       pop;

    // Advance a pointer with explicit wrap at DEPTH-1.
    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
        return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
    endfunction

    // Ready depends only on registered occupancy, so a same-cycle pop never
    // opens a full FIFO. It is held low while reset is asserted.
    assign data_in_ready  = (count != COUNT_WIDTH'(DEPTH)) && !rst;
    assign data_out_valid = (count != '0);
    assign push           = data_in_valid && data_in_ready;
    assign pop            = data_out_valid && data_out_ready;
    assign data_out       = mem[rd_ptr];

    // Storage, pointers and occupancy; reset clears the contents as well.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            mem    <= '{default: '0};
        end else begin
            if (push) begin
                mem[wr_ptr] <= data_in;
                wr_ptr      <= next_ptr(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            case ({push, pop})
                2'b10:   count <= count + COUNT_WIDTH'(1);
                2'b01:   count <= count - COUNT_WIDTH'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_fixed_vector_fifo.sv
// Bench for fixed_vector_fifo: two instances (DEPTH=4 and DEPTH=3) share the
// same stimulus; each has a queue-based reference model, and a monitor on the
// falling edge compares the flags, the occupancy and the head vector.
module tb_fixed_vector_fifo;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst;
    logic [1:0][3:0] din;
    logic            vin;
    logic            rout;

    logic            rdy4, vld4;
    logic [1:0][3:0] dout4;
    logic [2:0]      cnt4;
    logic            rdy3, vld3;
    logic [1:0][3:0] dout3;
    logic [1:0]      cnt3;

    fixed_vector_fifo #(.WIDTH(4), .SIZE(2), .DEPTH(4)) u_d4 (
        .clk(clk), .rst(rst),
        .data_in(din), .data_in_valid(vin), .data_in_ready(rdy4),
        .data_out(dout4), .data_out_valid(vld4), .data_out_ready(rout),
        .count(cnt4)
    );

    fixed_vector_fifo #(.WIDTH(4), .SIZE(2), .DEPTH(3)) u_d3 (
        .clk(clk), .rst(rst),
        .data_in(din), .data_in_valid(vin), .data_in_ready(rdy3),
        .data_out(dout3), .data_out_valid(vld3), .data_out_ready(rout),
        .count(cnt3)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: the FIFO is simply an ordered queue of accepted vectors.
    // zN marks "nothing accepted since reset", when the head must read as zero.
    logic [7:0] q4[$];
    logic [7:0] q3[$];
    bit         z4 = 1'b1;
    bit         z3 = 1'b1;
    int         popped3 = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic chk_fifo(input string tag, input int depth, input int sz,
                            input logic [7:0] head, input bit z, input logic r_in,
                            input logic v, input logic r, input logic [31:0] c,
                            input logic [7:0] d);
        check({tag, "_valid"}, 32'(v), 32'(sz != 0));
        check({tag, "_ready"}, 32'(r), 32'(!r_in && sz != depth));
        check({tag, "_count"}, c, 32'(sz));
        if (sz != 0)
            check({tag, "_data"}, 32'(d), 32'(head));
        else if (z)
            check({tag, "_zero"}, 32'(d), 32'h0);
    endtask

    // Model update on the active edge from the inputs presented in that cycle.
    always @(posedge clk) begin
        int s4;
        int s3;
        s4 = q4.size();
        s3 = q3.size();
        if (rst) begin
            q4.delete();
            q3.delete();
            z4 <= 1'b1;
            z3 <= 1'b1;
        end else begin
            if (s4 != 0 && rout) void'(q4.pop_front());
            if (vin && s4 != 4) begin
                q4.push_back(din);
                z4 <= 1'b0;
            end
            if (s3 != 0 && rout) begin
                void'(q3.pop_front());
                popped3 <= popped3 + 1;
            end
            if (vin && s3 != 3) begin
                q3.push_back(din);
                z3 <= 1'b0;
            end
        end
    end

    // Monitor: compare both instances against the model away from the edge.
    always @(negedge clk) begin
        logic [7:0] h4;
        logic [7:0] h3;
        h4 = (q4.size() != 0) ? q4[0] : 8'h00;
        h3 = (q3.size() != 0) ? q3[0] : 8'h00;
        chk_fifo("d4", 4, q4.size(), h4, z4, rst, vld4, rdy4, 32'(cnt4), dout4);
        chk_fifo("d3", 3, q3.size(), h3, z3, rst, vld3, rdy3, 32'(cnt3), dout3);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a vector and hold it until the chosen instance accepts it.
    task automatic push_hold(input logic [7:0] v, input bit on3, input bit rnd);
        bit acc;
        acc = 1'b0;
        vin = 1'b1;
        din = v;
        for (int k = 0; k < 20 && !acc; k++) begin
            if (rnd) rout = 1'($urandom_range(0, 1));
            @(negedge clk);
            acc = on3 ? rdy3 : rdy4;
            @(posedge clk);
            #1;
        end
        if (!acc) check("push_accept_timeout", 32'(acc), 32'h1);
        vin = 1'b0;
    endtask

    task automatic reset_cycles(input int n);
        rst = 1'b1;
        vin = 1'b0;
        rout = 1'b0;
        repeat (n) tick();
        rst = 1'b0;
    endtask

    initial begin
        int base;
        rst  = 1'b1;
        vin  = 1'b0;
        rout = 1'b0;
        din  = '0;

        // Reset then a single vector {3,1} with the consumer stalled.
        reset_cycles(2);
        din = 8'h31;
        vin = 1'b1;
        tick();
        vin = 1'b0;
        repeat (2) tick();

        // Fill to full, hold a fifth vector, then one pop frees a slot.
        reset_cycles(1);
        push_hold(8'h11, 1'b0, 1'b0);
        push_hold(8'h22, 1'b0, 1'b0);
        push_hold(8'h33, 1'b0, 1'b0);
        push_hold(8'h44, 1'b0, 1'b0);
        din = 8'h55;
        vin = 1'b1;
        repeat (3) tick();
        rout = 1'b1;
        tick();
        rout = 1'b0;
        push_hold(8'h55, 1'b0, 1'b0);
        repeat (2) tick();

        // Two buffered, then ten cycles of simultaneous push and pop.
        reset_cycles(1);
        push_hold(8'hA1, 1'b0, 1'b0);
        push_hold(8'hB2, 1'b0, 1'b0);
        vin  = 1'b1;
        rout = 1'b1;
        for (int i = 0; i < 10; i++) begin
            din = 8'($urandom);
            tick();
        end

        // Backpressure: head must hold for five stalled cycles.
        vin  = 1'b0;
        rout = 1'b0;
        repeat (5) tick();

        // Reach three entries, then reset while both handshakes are requested.
        push_hold(8'hC3, 1'b0, 1'b0);
        rst  = 1'b1;
        vin  = 1'b1;
        rout = 1'b1;
        din  = 8'hEE;
        tick();
        rst  = 1'b0;
        rout = 1'b0;
        din  = 8'h62;
        tick();
        vin = 1'b0;
        repeat (2) tick();

        // DEPTH=3: seven vectors {i,15-i} with random consumer readiness.
        reset_cycles(1);
        base = popped3;
        for (int i = 0; i < 7; i++)
            push_hold({4'(i), 4'(15 - i)}, 1'b1, 1'b1);
        for (int k = 0; k < 100 && q3.size() != 0; k++) begin
            rout = 1'($urandom_range(0, 1));
            tick();
        end
        rout = 1'b0;
        tick();
        check("d3_seven_drained", 32'(popped3 - base), 32'd7);

        // Random traffic with occasional reset.
        for (int i = 0; i < 400; i++) begin
            rst  = ($urandom_range(0, 49) == 0);
            vin  = 1'($urandom_range(0, 1));
            rout = ($urandom_range(0, 3) != 0) ? 1'($urandom_range(0, 1)) : 1'b0;
            din  = 8'($urandom);
            tick();
        end
        rst  = 1'b0;
        vin  = 1'b0;
        rout = 1'b1;
        repeat (6) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
